// File: rtl/record_producer_types.sv
// Shared types for the record producer and the record-consuming blocks it drives.
//   record_t                    : {x: signed 32, y: unsigned 32}, x in the upper half
//   record_producer_sections_t  : producer FSM states
package record_producer_types;

  typedef struct packed {
    logic signed [31:0] x;
    logic        [31:0] y;
  } record_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } record_producer_sections_t;

endpackage

// File: rtl/record_seq_gen.sv
// Deterministic record sequence source for record_producer.
// Holds the transaction index (record.y) and the x accumulator (record.x).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : restart the sequence at {x: X_START, y: 0}
//   advance   : step to the next record (x += X_STEP, y += 1)
//   rec       : current record, registered, packed as record_t
module record_seq_gen #(
  parameter logic signed [31:0] X_START = 32'sd0,
  parameter logic signed [31:0] X_STEP  = 32'sd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [63:0] rec
);
  import record_producer_types::*;

  record_t rec_r;

  // Sequence register: load has priority over advance; x wraps mod 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_r <= '0;
    end else if (load) begin
      rec_r.x <= X_START;
      rec_r.y <= 32'd0;
    end else if (advance) begin
      rec_r.x <= rec_r.x + X_STEP;
      rec_r.y <= rec_r.y + 32'd1;
    end else begin
      rec_r <= rec_r;
    end
  end

  assign rec = rec_r;

endmodule

// File: rtl/record_producer.sv
// Record producer: initiator for the record_t blocking-port protocol.
// Sends a deterministic sequence of records over a sync/notify output port,
// waits for a 32-bit result after each send and accumulates a checksum.
// Optional wait timeout in RECV is built only when RECORD_PRODUCER_TIMEOUT_EN
// is defined; otherwise timeout_err is tied 0.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, starts a run from IDLE or DONE
//   rec_out         : record offered to the consumer ({x, y})
//   rec_out_sync    : consumer ready; beat when rec_out_notify && rec_out_sync
//   rec_out_notify  : rec_out valid
//   res_in          : result from the consumer
//   res_in_sync     : res_in valid; beat when res_in_notify && res_in_sync
//   res_in_notify   : producer ready for res_in
//   done            : run complete
//   txn_count       : completed transactions in the current run
//   checksum        : sum of received results, mod 2^32
//   last_result     : most recently captured res_in
//   timeout_err     : sticky timeout flag
module record_producer #(
  parameter logic        [31:0] NUM_TXN = 32'd8,
  parameter logic signed [31:0] X_START = 32'sd0,
  parameter logic signed [31:0] X_STEP  = 32'sd1,
  parameter logic        [7:0]  TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [63:0] rec_out,
  input  logic        rec_out_sync,
  output logic        rec_out_notify,
  input  logic [31:0] res_in,
  input  logic        res_in_sync,
  output logic        res_in_notify,
  output logic        done,
  output logic [31:0] txn_count,
  output logic [31:0] checksum,
  output logic [31:0] last_result,
  output logic        timeout_err
);
  import record_producer_types::*;

  record_producer_sections_t state_r;
  logic        rec_out_notify_r;
  logic        res_in_notify_r;
  logic        done_r;
  logic [31:0] txn_count_r;
  logic [31:0] checksum_r;
  logic [31:0] last_result_r;

  logic        start_ok_s;
  logic        recv_fire_s;
  logic        last_txn_s;
  logic        advance_s;
  logic        timeout_hit_s;

  // A start pulse only counts while the producer is idle or finished.
  always_comb begin
    start_ok_s = 1'b0;
    case (state_r)
      IDLE, DONE: start_ok_s = start;
      SEND, RECV: start_ok_s = 1'b0;
      default:    start_ok_s = 1'b0;
    endcase
  end

  assign recv_fire_s = (state_r == RECV) && res_in_notify_r && res_in_sync;
  // NUM_TXN of zero means the run never ends.
  assign last_txn_s  = (NUM_TXN != 32'd0) && ((txn_count_r + 32'd1) == NUM_TXN);
  assign advance_s   = recv_fire_s && !last_txn_s;

  record_seq_gen #(
    .X_START (X_START),
    .X_STEP  (X_STEP)
  ) u_seq_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok_s),
    .advance (advance_s),
    .rec     (rec_out)
  );

`ifdef RECORD_PRODUCER_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
  logic       timeout_err_r;

  // A result beat always wins over a timeout that would fire in the same cycle.
  assign timeout_hit_s = (state_r == RECV) && !res_in_sync && ((wait_cnt_r + 8'd1) == TIMEOUT);

  // Wait counter: zero outside RECV so it starts clean on every RECV entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r != RECV) begin
      wait_cnt_r <= 8'd0;
    end else if (!res_in_sync) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky timeout flag, cleared only by reset or a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (start_ok_s) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  logic unused_timeout_s;

  assign unused_timeout_s = ^TIMEOUT;
  assign timeout_hit_s    = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // Producer FSM with its handshake flags and result accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      rec_out_notify_r <= 1'b0;
      res_in_notify_r  <= 1'b0;
      done_r           <= 1'b0;
      txn_count_r      <= 32'd0;
      checksum_r       <= 32'd0;
      last_result_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_ok_s) begin
            state_r          <= SEND;
            rec_out_notify_r <= 1'b1;
            res_in_notify_r  <= 1'b0;
            done_r           <= 1'b0;
            txn_count_r      <= 32'd0;
            checksum_r       <= 32'd0;
          end
        end
        SEND: begin
          if (rec_out_notify_r && rec_out_sync) begin
            state_r          <= RECV;
            rec_out_notify_r <= 1'b0;
            res_in_notify_r  <= 1'b1;
          end
        end
        RECV: begin
          if (recv_fire_s) begin
            last_result_r   <= res_in;
            checksum_r      <= checksum_r + res_in;
            txn_count_r     <= txn_count_r + 32'd1;
            res_in_notify_r <= 1'b0;
            if (last_txn_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r          <= SEND;
              rec_out_notify_r <= 1'b1;
            end
          end else if (timeout_hit_s) begin
            state_r         <= DONE;
            done_r          <= 1'b1;
            res_in_notify_r <= 1'b0;
          end
        end
        default: begin
          state_r          <= IDLE;
          rec_out_notify_r <= 1'b0;
          res_in_notify_r  <= 1'b0;
          done_r           <= 1'b0;
        end
      endcase
    end
  end

  assign rec_out_notify = rec_out_notify_r;
  assign res_in_notify  = res_in_notify_r;
  assign done           = done_r;
  assign txn_count      = txn_count_r;
  assign checksum       = checksum_r;
  assign last_result    = last_result_r;

endmodule

// File: tb/tb_record_producer.sv
// Self-checking bench for record_producer: a default instance (a) and a
// short negative-step instance (b) with TIMEOUT=4.
module tb_record_producer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_rec_out_sync, a_res_in_sync;
  logic [31:0] a_res_in;
  logic [63:0] a_rec_out;
  logic        a_rec_out_notify, a_res_in_notify, a_done, a_timeout_err;
  logic [31:0] a_txn_count, a_checksum, a_last_result;

  logic        b_start, b_rec_out_sync, b_res_in_sync;
  logic [31:0] b_res_in;
  logic [63:0] b_rec_out;
  logic        b_rec_out_notify, b_res_in_notify, b_done, b_timeout_err;
  logic [31:0] b_txn_count, b_checksum, b_last_result;

  record_producer u_dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .rec_out(a_rec_out), .rec_out_sync(a_rec_out_sync), .rec_out_notify(a_rec_out_notify),
    .res_in(a_res_in), .res_in_sync(a_res_in_sync), .res_in_notify(a_res_in_notify),
    .done(a_done), .txn_count(a_txn_count), .checksum(a_checksum),
    .last_result(a_last_result), .timeout_err(a_timeout_err)
  );

  record_producer #(
    .NUM_TXN(32'd3), .X_START(-32'sd3), .X_STEP(-32'sd2), .TIMEOUT(8'd4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .rec_out(b_rec_out), .rec_out_sync(b_rec_out_sync), .rec_out_notify(b_rec_out_notify),
    .res_in(b_res_in), .res_in_sync(b_res_in_sync), .res_in_notify(b_res_in_notify),
    .done(b_done), .txn_count(b_txn_count), .checksum(b_checksum),
    .last_result(b_last_result), .timeout_err(b_timeout_err)
  );

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];

  typedef struct {
    logic [31:0] res;
    logic [63:0] rec;
    logic [31:0] chk;
    logic [31:0] txn;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkrec(input int i, input int xs, input int xst);
    logic signed [31:0] x;
    logic [31:0] y;
    x = xs + i * xst;
    y = i;
    return {x, y};
  endfunction

  // Check any record beat about to complete against the scoreboard, then advance a cycle.
  task automatic tick();
    if (!rst && a_rec_out_notify && a_rec_out_sync) begin
      if (exp_q_a.size() == 0) begin
        vec_cnt++; miscmp_cnt++;
        $display("FAIL a_extra_beat: got %0h expected no beat", a_rec_out);
      end else begin
        chk("a_rec_beat", a_rec_out, exp_q_a.pop_front());
      end
    end
    if (!rst && b_rec_out_notify && b_rec_out_sync) begin
      if (exp_q_b.size() == 0) begin
        vec_cnt++; miscmp_cnt++;
        $display("FAIL b_extra_beat: got %0h expected no beat", b_rec_out);
      end else begin
        chk("b_rec_beat", b_rec_out, exp_q_b.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sum;
    int cyc;

    rst = 1'b1;
    a_start = 1'b0; a_rec_out_sync = 1'b0; a_res_in_sync = 1'b0; a_res_in = 32'd0;
    b_start = 1'b0; b_rec_out_sync = 1'b0; b_res_in_sync = 1'b0; b_res_in = 32'd0;

    sum = 32'd0;
    for (int i = 0; i < 8; i++) begin
      tbl[i].res = 32'(10 * (i + 1));
      sum        = sum + tbl[i].res;
      tbl[i].rec = mkrec(i, 0, 1);
      tbl[i].chk = sum;
      tbl[i].txn = 32'(i + 1);
    end

    // Reset values
    #12;
    chk("a_reset_rec", a_rec_out, 64'd0);
    chk("a_reset_flags", 64'({a_rec_out_notify, a_res_in_notify, a_done, a_timeout_err}), 64'd0);
    chk("a_reset_counters", 64'({a_txn_count, a_checksum}), 64'd0);
    chk("a_reset_last", 64'(a_last_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // Full default run, both syncs held high
    a_rec_out_sync = 1'b1;
    a_res_in_sync  = 1'b1;
    for (int i = 0; i < 8; i++) exp_q_a.push_back(tbl[i].rec);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("a_send_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd4);
      chk("a_send_rec", a_rec_out, tbl[i].rec);
      a_res_in = tbl[i].res;
      tick();
      chk("a_recv_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd2);
      tick();
      chk("a_checksum", 64'(a_checksum), 64'(tbl[i].chk));
      chk("a_txn_count", 64'(a_txn_count), 64'(tbl[i].txn));
      chk("a_last_result", 64'(a_last_result), 64'(tbl[i].res));
    end
    chk("a_done_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd1);
    chk("a_final_checksum", 64'(a_checksum), 64'd360);
    chk("a_final_last", 64'(a_last_result), 64'd80);
    chk("a_final_txn", 64'(a_txn_count), 64'd8);

    // Restart from DONE with the consumer stalled; res_in_sync high while not wanted
    a_rec_out_sync = 1'b0;
    a_res_in_sync  = 1'b1;
    a_res_in       = 32'd999;
    for (int i = 0; i < 3; i++) exp_q_a.push_back(mkrec(i, 0, 1));
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_restart_counters", 64'({a_txn_count, a_checksum}), 64'd0);
    chk("a_restart_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd4);
    for (int k = 0; k < 5; k++) begin
      a_start = (k == 2);
      tick();
      a_start = 1'b0;
      chk("a_stall_rec", a_rec_out, mkrec(0, 0, 1));
      chk("a_stall_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd4);
      chk("a_stall_checksum", 64'(a_checksum), 64'd0);
    end
    a_rec_out_sync = 1'b1;
    tick();
    chk("a_unstall_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd2);
    a_rec_out_sync = 1'b0;
    a_res_in = 32'd7;
    tick();
    chk("a_stall_txn1_checksum", 64'(a_checksum), 64'd7);
    chk("a_stall_txn1_rec", a_rec_out, mkrec(1, 0, 1));
    a_res_in = 32'd1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("a_ignored_sync_checksum", 64'(a_checksum), 64'd7);
      chk("a_ignored_sync_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd4);
    end
    a_rec_out_sync = 1'b1;
    tick();
    a_rec_out_sync = 1'b0;
    a_res_in = 32'd5;
    tick();
    chk("a_txn2_counters", 64'({a_txn_count, a_checksum}), {32'd2, 32'd12});
    a_rec_out_sync = 1'b1;
    tick();
    a_rec_out_sync = 1'b0;
    a_res_in_sync  = 1'b0;
    chk("a_pre_reset_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd2);

    // Asynchronous reset in RECV, mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("a_async_rst_rec", a_rec_out, 64'd0);
    chk("a_async_rst_flags", 64'({a_rec_out_notify, a_res_in_notify, a_done, a_timeout_err}), 64'd0);
    chk("a_async_rst_counters", 64'({a_txn_count, a_checksum}), 64'd0);
    chk("a_async_rst_last", 64'(a_last_result), 64'd0);
    chk("a_queue_drained", 64'(exp_q_a.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    a_rec_out_sync = 1'b1;
    exp_q_a.push_back(mkrec(0, 0, 1));
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_post_rst_rec", a_rec_out, mkrec(0, 0, 1));
    chk("a_post_rst_state", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd4);
    tick();
    a_rec_out_sync = 1'b0;
    chk("a_post_rst_recv", 64'({a_rec_out_notify, a_res_in_notify, a_done}), 64'd2);

    // Instance b: negative step, three transactions, results wrap the checksum
    b_rec_out_sync = 1'b1;
    b_res_in_sync  = 1'b1;
    b_res_in       = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) exp_q_b.push_back(mkrec(i, -3, -2));
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_first_rec", b_rec_out, {32'hFFFF_FFFD, 32'd0});
    cyc = 0;
    while (!b_done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_cycles", 64'(cyc), 64'd6);
    chk("b_txn_count", 64'(b_txn_count), 64'd3);
    chk("b_checksum_wrap", 64'(b_checksum), 64'hFFFF_FFFD);
    chk("b_last_result", 64'(b_last_result), 64'hFFFF_FFFF);
    chk("b_last_rec", b_rec_out, {32'hFFFF_FFF9, 32'd2});

`ifdef RECORD_PRODUCER_TIMEOUT_EN
    b_res_in_sync = 1'b0;
    exp_q_b.push_back(mkrec(0, -3, -2));
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    chk("b_to_recv", 64'({b_rec_out_notify, b_res_in_notify, b_done, b_timeout_err}), 64'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b_to_waiting", 64'({b_rec_out_notify, b_res_in_notify, b_done, b_timeout_err}), 64'd4);
    end
    tick();
    chk("b_to_fired", 64'({b_rec_out_notify, b_res_in_notify, b_done, b_timeout_err}), 64'd3);
    chk("b_to_counters", 64'({b_txn_count, b_checksum}), 64'd0);
`else
    chk("b_timeout_tied", 64'(b_timeout_err), 64'd0);
`endif

    chk("a_queue_empty", 64'(exp_q_a.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_q_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
